// File: rtl/packet_switch_allocator_if.sv
// Request/grant bundle between the input buffers, one output allocator and its crossbar select.
// Master drives requests and flit info; slave (the allocator) returns grant, transfer and status.
interface packet_switch_allocator_if #(
    parameter int N_PORTS = 5,
    parameter int LEN_W   = 12
);
    logic [N_PORTS-1:0]       req;
    logic [3*N_PORTS-1:0]     flit_id;
    logic [LEN_W*N_PORTS-1:0] length;
    logic                     out_ready;
    logic [N_PORTS-1:0]       grant;
    logic [2:0]               grant_idx;
    logic                     xfer;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        output req, flit_id, length, out_ready,
        input  grant, grant_idx, xfer, busy, timeout_err
    );

    modport slave (
        input  req, flit_id, length, out_ready,
        output grant, grant_idx, xfer, busy, timeout_err
    );
endinterface

// File: rtl/packet_switch_allocator.sv
// Wormhole output allocator: round-robin over head flits, grant one cycle after head req, held until tail xfer.
// out_ready=0 or a dropped req stalls xfer but keeps the lock; define PSA_WATCHDOG_EN to release stalled locks.
module packet_switch_allocator #(
    parameter int N_PORTS = 5,
    parameter int LEN_W   = 12,
    parameter int SLACK   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    packet_switch_allocator_if.slave bus
);

`ifdef PSA_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, LOCK, TOUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOCK} state_t;
`endif

    state_t             state, state_n;
    logic [N_PORTS-1:0] grant_q, grant_n;
    logic [2:0]         idx_q, idx_n;
    logic [2:0]         rr_ptr, rr_n;
    logic [2:0]         rr_after;
    logic [N_PORTS-1:0] cand;
    logic               found;
    logic [2:0]         win;
    logic [2:0]         pos;
    logic [2:0]         g_id;
    logic [LEN_W-1:0]   win_len;
    logic               xfer;
    logic               tail_xfer;
    logic               unused_sig;

`ifdef PSA_WATCHDOG_EN
    logic [LEN_W:0]     wd_cnt, wd_cnt_n;
    logic [LEN_W:0]     wd_limit, wd_limit_n;
`endif

    // Only head flits may start a packet; a body/tail seen while idle is a stray mid-packet flit.
    always_comb begin
        cand = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand[i] = bus.req[i] & bus.flit_id[3*i];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            pos = (int'(rr_ptr) + k >= N_PORTS) ? 3'(int'(rr_ptr) + k - N_PORTS)
                                                : 3'(int'(rr_ptr) + k);
            if (!found && cand[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
    end

    always_comb begin
        g_id    = '0;
        win_len = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (idx_q == 3'(i)) g_id    = bus.flit_id[3*i +: 3];
            if (win == 3'(i))   win_len = bus.length[LEN_W*i +: LEN_W];
        end
    end

    assign rr_after  = (idx_q == 3'(N_PORTS - 1)) ? 3'd0 : idx_q + 3'd1;
    assign xfer      = (state == LOCK) & bus.req[idx_q] & bus.out_ready;
    assign tail_xfer = xfer & g_id[2];

    always_comb begin
        state_n    = state;
        grant_n    = grant_q;
        idx_n      = idx_q;
        rr_n       = rr_ptr;
`ifdef PSA_WATCHDOG_EN
        wd_cnt_n   = wd_cnt;
        wd_limit_n = wd_limit;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n    = LOCK;
                    grant_n    = N_PORTS'(1) << win;
                    idx_n      = win;
`ifdef PSA_WATCHDOG_EN
                    wd_cnt_n   = '0;
                    wd_limit_n = {1'b0, win_len} + (LEN_W+1)'(SLACK);
`endif
                end
            end
            LOCK: begin
`ifdef PSA_WATCHDOG_EN
                wd_cnt_n = wd_cnt + (LEN_W+1)'(1);
`endif
                // A tail moving on the limit cycle is a normal release, so it is tested first.
                if (tail_xfer) begin
                    state_n = IDLE;
                    grant_n = '0;
                    idx_n   = '0;
                    rr_n    = rr_after;
                end
`ifdef PSA_WATCHDOG_EN
                else if (wd_cnt == wd_limit) begin
                    state_n = TOUT;
                    grant_n = '0;
                    idx_n   = '0;
                    rr_n    = rr_after;
                end
`endif
            end
`ifdef PSA_WATCHDOG_EN
            TOUT: begin
                state_n = IDLE;
            end
`endif
            default: begin
                state_n = IDLE;
                grant_n = '0;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            idx_q   <= idx_n;
            rr_ptr  <= rr_n;
        end
    end

`ifdef PSA_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt   <= '0;
            wd_limit <= '0;
        end else begin
            wd_cnt   <= wd_cnt_n;
            wd_limit <= wd_limit_n;
        end
    end

    assign bus.timeout_err = (state == TOUT);
    assign unused_sig      = ^g_id[1:0];
`else
    assign bus.timeout_err = 1'b0;
    assign unused_sig      = ^{bus.length, win_len, g_id[1:0]};
`endif

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy      = (state == LOCK);
    assign bus.xfer      = xfer;

endmodule
